// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory slave with fixed response latency.
// A request is captured in S_IDLE, waited out in S_WAIT and completed with a
// one-cycle mem_resp pulse in S_RESP; writes commit on the edge ending S_RESP.
module mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1eceb000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_rmask,
  input  logic [3:0]  mem_wmask,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        mem_err
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic [3:0]  cnt_next;

  logic [31:0] addr_q;
  logic [3:0]  rmask_q;
  logic [3:0]  wmask_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_hold;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic [29:0] word_off;
  logic        in_range;
  logic        is_write;
  logic        malformed;
  logic [AW-1:0] word_idx;
  logic [31:0] stored_word;
  logic [31:0] resp_rdata;
  logic [31:0] merged_word;
  logic        unused_addr_bits;

  // Byte offset bits never select anything: accesses are always word-aligned.
  assign unused_addr_bits = ^{mem_addr[1:0], addr_q[1:0]};

  assign accept = (state == S_IDLE) && ((mem_rmask != 4'd0) || (mem_wmask != 4'd0));

  // Word distance from the base; wrap-around below BASE_ADDR lands far out of range.
  assign word_off    = addr_q[31:2] - BASE_ADDR[31:2];
  assign in_range    = word_off < 30'(DEPTH_WORDS);
  assign word_idx    = word_off[AW-1:0];
  assign is_write    = wmask_q != 4'd0;
  assign malformed   = (rmask_q != 4'd0) && is_write;
  assign stored_word = mem[word_idx];
  assign resp_rdata  = in_range ? stored_word : 32'd0;

  // Merge the captured write lanes over the currently stored word.
  always_comb begin
    merged_word = stored_word;
    for (int i = 0; i < 4; i++) begin
      if (wmask_q[i]) begin
        merged_word[8*i +: 8] = wdata_q[8*i +: 8];
      end
    end
  end

  // State and latency counter register; reset aborts any request in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: accept in idle, count down in wait, always leave resp.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_next = S_RESP;
          end else begin
            state_next = S_WAIT;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_next = S_RESP;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      S_RESP: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // Capture the request fields once; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      addr_q  <= mem_addr;
      rmask_q <= mem_rmask;
      wmask_q <= mem_wmask;
      wdata_q <= mem_wdata;
    end
  end

  // Keep the last response data visible after S_RESP ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_hold <= 32'd0;
    end else if (state == S_RESP) begin
      rdata_hold <= resp_rdata;
    end
  end

  // Commit an in-range write on the edge that ends S_RESP; storage survives reset.
  always_ff @(posedge clk) begin
    if (!rst && (state == S_RESP) && in_range && is_write) begin
      mem[word_idx] <= merged_word;
    end
  end

  assign mem_resp  = !rst && (state == S_RESP);
  assign mem_err   = mem_resp && (!in_range || malformed);
  assign mem_rdata = rst ? 32'd0 : ((state == S_RESP) ? resp_rdata : rdata_hold);

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: drives a LATENCY=2 and a LATENCY=1 responder with directed
// and random requests and compares against an address-keyed reference store.
module tb_mem_responder;

  localparam logic [31:0] BASE = 32'h1eceb000;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_rmask;
  logic [3:0]  req_wmask;
  logic [3:0]  rmask0, wmask0, rmask1, wmask1;
  logic [31:0] rdata0, rdata1;
  logic        resp0, resp1, err0, err1;

  int checks = 0;
  int errors = 0;

  // Reference store: key = instance*65536 + word index; only fully known words.
  bit [31:0] mdl [int];

  always #5 clk = ~clk;

  assign rmask0 = sel ? 4'd0 : req_rmask;
  assign wmask0 = sel ? 4'd0 : req_wmask;
  assign rmask1 = sel ? req_rmask : 4'd0;
  assign wmask1 = sel ? req_wmask : 4'd0;

  mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(4096), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .mem_addr(req_addr), .mem_rmask(rmask0),
    .mem_wmask(wmask0), .mem_wdata(req_wdata), .mem_rdata(rdata0),
    .mem_resp(resp0), .mem_err(err0)
  );

  mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(16), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .mem_addr(req_addr), .mem_rmask(rmask1),
    .mem_wmask(wmask1), .mem_wdata(req_wdata), .mem_rdata(rdata1),
    .mem_resp(resp1), .mem_err(err1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction, started and ended just after a negedge.
  task automatic applyStimulus(input bit s, input logic [31:0] a, input logic [3:0] rm,
                               input logic [3:0] wm, input logic [31:0] wd, input bit hold);
    int          lat;
    int          depth;
    int          n;
    int          key;
    bit          got;
    bit          oor;
    bit          known;
    bit          exp_err;
    longint      off;
    logic [31:0] exp_data;
    logic [31:0] merged;
    logic [31:0] aligned;
    lat     = s ? 1 : 2;
    depth   = s ? 16 : 4096;
    aligned = {a[31:2], 2'b00};
    off     = longint'(aligned) - longint'(BASE);
    oor     = (off < 0) || (off >= 4 * longint'(depth));
    key     = oor ? -1 : (int'(s) * 65536 + int'(off / 4));
    known   = !oor && mdl.exists(key);
    exp_data = oor ? 32'd0 : (known ? mdl[key] : 32'hx);
    exp_err = oor || ((rm != 4'd0) && (wm != 4'd0));

    sel = s; req_addr = a; req_rmask = rm; req_wmask = wm; req_wdata = wd;
    @(posedge clk);
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if ((s ? resp1 : resp0) === 1'b1) begin
        got = 1;
      end else if (!hold) begin
        req_addr  = $urandom;
        req_rmask = 4'($urandom);
        req_wmask = 4'($urandom);
        req_wdata = $urandom;
      end
    end
    checkOutput("resp_seen", 32'(got), 32'd1);
    checkOutput("latency", n, lat);
    checkOutput("err", 32'(s ? err1 : err0), 32'(exp_err));
    if (oor || known) checkOutput("rdata", s ? rdata1 : rdata0, exp_data);

    if (!oor && wm != 4'd0) begin
      if (known) begin
        merged = mdl[key];
        for (int i = 0; i < 4; i++) if (wm[i]) merged[8*i +: 8] = wd[8*i +: 8];
        mdl[key] = merged;
      end else if (wm == 4'hf) begin
        mdl[key] = wd;
      end
    end

    if (hold) begin
      n = 0; got = 0;
      while (!got && n < 20) begin
        @(negedge clk);
        n++;
        if ((s ? resp1 : resp0) === 1'b1) got = 1;
      end
      checkOutput("hold_resp_seen", 32'(got), 32'd1);
      checkOutput("hold_spacing", n, lat + 1);
      checkOutput("hold_err", 32'(s ? err1 : err0), 32'(exp_err));
      if (oor || known) checkOutput("hold_rdata", s ? rdata1 : rdata0, exp_data);
    end

    req_rmask = 4'd0;
    req_wmask = 4'd0;
    @(negedge clk);
    checkOutput("idle_resp", 32'(s ? resp1 : resp0), 32'd0);
    checkOutput("idle_err", 32'(s ? err1 : err0), 32'd0);
    if (oor || known) checkOutput("idle_rdata", s ? rdata1 : rdata0, exp_data);
  endtask

  // Global bound so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  // Main sequence: reset behaviour, directed cases, then randomized traffic.
  initial begin
    bit          seen;
    int          depth;
    int          r;
    logic [31:0] a;
    logic [3:0]  rm;
    logic [3:0]  wm;

    rst = 1'b1; sel = 1'b0; req_addr = BASE;
    req_rmask = 4'hf; req_wmask = 4'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_resp0", 32'(resp0), 32'd0);
    checkOutput("reset_err0", 32'(err0), 32'd0);
    checkOutput("reset_rdata0", rdata0, 32'd0);
    checkOutput("reset_resp1", 32'(resp1), 32'd0);
    checkOutput("reset_err1", 32'(err1), 32'd0);
    checkOutput("reset_rdata1", rdata1, 32'd0);
    rst = 1'b0; req_rmask = 4'd0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp0 === 1'b1 || resp1 === 1'b1) seen = 1;
    end
    checkOutput("no_resp_for_reset_req", 32'(seen), 32'd0);

    $display("[TB] directed LATENCY=2");
    applyStimulus(0, BASE, 4'd0, 4'hf, 32'hdeadbeef, 0);
    applyStimulus(0, BASE, 4'hf, 4'd0, 32'd0, 0);
    applyStimulus(0, BASE + 4, 4'd0, 4'hf, 32'h11223344, 0);
    applyStimulus(0, BASE + 4, 4'd0, 4'b0100, 32'h00aa0000, 0);
    applyStimulus(0, BASE + 4, 4'hf, 4'd0, 32'd0, 0);
    checkOutput("byte_merge_const", rdata0, 32'h11aa3344);
    applyStimulus(0, BASE + 4 * 4095, 4'd0, 4'hf, 32'h0f0f0f0f, 0);
    applyStimulus(0, BASE - 4, 4'hf, 4'd0, 32'd0, 0);
    applyStimulus(0, BASE - 4, 4'd0, 4'hf, 32'hffffffff, 0);
    applyStimulus(0, BASE + 4 * 4096, 4'hf, 4'd0, 32'd0, 0);
    applyStimulus(0, BASE + 4 * 4096, 4'd0, 4'hf, 32'hffffffff, 0);
    applyStimulus(0, BASE, 4'hf, 4'd0, 32'd0, 0);
    applyStimulus(0, BASE + 4 * 4095, 4'hf, 4'd0, 32'd0, 0);
    applyStimulus(0, BASE, 4'hf, 4'd0, 32'd0, 1);

    $display("[TB] reset during wait");
    applyStimulus(0, BASE + 8, 4'd0, 4'hf, 32'h0badcafe, 0);
    applyStimulus(0, BASE + 8, 4'd0, 4'hf, 32'h0badcafe, 0);
    sel = 1'b0; req_addr = BASE + 8; req_rmask = 4'd0; req_wmask = 4'hf; req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_wait_noresp", 32'(resp0), 32'd0);
    rst = 1'b1; req_wmask = 4'd0;
    @(negedge clk);
    checkOutput("rst_resp", 32'(resp0), 32'd0);
    checkOutput("rst_err", 32'(err0), 32'd0);
    checkOutput("rst_rdata", rdata0, 32'd0);
    rst = 1'b0;
    applyStimulus(0, BASE + 8, 4'hf, 4'd0, 32'd0, 0);

    $display("[TB] directed LATENCY=1");
    applyStimulus(1, BASE + 8, 4'd0, 4'hf, 32'h55667788, 0);
    applyStimulus(1, BASE + 8, 4'b0001, 4'b0001, 32'h000000ab, 0);
    applyStimulus(1, BASE + 8, 4'hf, 4'd0, 32'd0, 0);
    checkOutput("malformed_byte_const", rdata1, 32'h556677ab);
    applyStimulus(1, BASE, 4'd0, 4'hf, 32'h01020304, 0);
    applyStimulus(1, BASE + 64, 4'd0, 4'hf, 32'hffffffff, 0);
    applyStimulus(1, BASE, 4'hf, 4'd0, 32'd0, 1);

    $display("[TB] randomized traffic");
    for (int s = 0; s < 2; s++) begin
      depth = (s == 1) ? 16 : 4096;
      for (int w = 0; w < 8; w++) applyStimulus(s[0], BASE + 32'(4 * w), 4'd0, 4'hf, $urandom, 0);
      for (int k = 0; k < 40; k++) begin
        r = $urandom_range(0, 9);
        if (r == 0)      a = BASE - 32'(4 * $urandom_range(1, 4));
        else if (r == 1) a = BASE + 32'(4 * depth) + 32'(4 * $urandom_range(0, 3));
        else             a = BASE + 32'(4 * $urandom_range(0, 7));
        a[1:0] = 2'($urandom_range(0, 3));
        rm = 4'($urandom);
        wm = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
        if (rm == 4'd0 && wm == 4'd0) rm = 4'hf;
        applyStimulus(s[0], a, rm, wm, $urandom, (wm == 4'd0) && ($urandom_range(0, 4) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
